// File: rtl/axis_pkt_fifo_pkg.sv
// Shared types for the AXI4-Stream packet FIFO.
// Word layout, release FSM states and width helper.
package axis_pkt_fifo_pkg;

  localparam int AXIS_DATA_W = 32;
  localparam int AXIS_KEEP_W = AXIS_DATA_W / 8;

  typedef struct packed {
    logic [AXIS_DATA_W-1:0] data;
    logic [AXIS_KEEP_W-1:0] keep;
    logic                   last;
  } axis_word_t;

  typedef enum logic {
    IDLE,
    RELEASE
  } rel_state_t;

  function automatic int word_w(int dw);
    return dw + dw / 8 + 1;
  endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port RAM with registered read.
// A same-cycle write to the read address is forwarded to rdata.
module axis_fifo_ram #(
  parameter int W     = 37,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
    if (we && waddr == raddr)
      rdata <= wdata;
    else
      rdata <= mem[raddr];
  end

endmodule

// File: rtl/axis_pkt_fifo.sv
// AXI4-Stream FIFO with cut-through or store-and-forward output
// and forced release of packets too large to ever complete.
module axis_pkt_fifo
  import axis_pkt_fifo_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int STORE_FWD = 0,
  localparam int KW       = DATA_W / 8,
  localparam int AW       = $clog2(DEPTH),
  localparam int PW       = AW + 1
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic [KW-1:0]     s_axis_tkeep,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [KW-1:0]     m_axis_tkeep,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [PW-1:0]     fill_level,
  output logic [PW-1:0]     pkt_count,
  output logic              oversize_err
);

  localparam int WW = word_w(DATA_W);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_next;
  logic [PW-1:0] fill_q;
  logic [PW-1:0] pkt_q;
  logic          rst_q;
  rel_state_t    state;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          push_last;
  logic          pop_last;
  logic [WW-1:0] rdata;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  assign s_axis_tready = !rst_q && !full;
  assign m_axis_tvalid = !empty &&
                         (STORE_FWD == 0 || pkt_q != '0 ||
                          state == RELEASE);

  // A packet filling the whole FIFO can never see its tlast buffered.
  assign oversize_err = (STORE_FWD != 0) && state == IDLE &&
                        full && pkt_q == '0;

  assign push      = s_axis_tvalid && s_axis_tready;
  assign pop       = m_axis_tvalid && m_axis_tready;
  assign push_last = push && s_axis_tlast;
  assign pop_last  = pop && m_axis_tlast;
  assign rd_next   = rd_ptr + PW'(pop);

  assign m_axis_tdata = rdata[WW-1 -: DATA_W];
  assign m_axis_tkeep = rdata[KW:1];
  assign m_axis_tlast = rdata[0];
  assign fill_level   = fill_q;
  assign pkt_count    = pkt_q;

  axis_fifo_ram #(
    .W     (WW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (aclk),
    .we    (push),
    .waddr (wr_ptr[AW-1:0]),
    .wdata ({s_axis_tdata, s_axis_tkeep, s_axis_tlast}),
    .raddr (rd_next[AW-1:0]),
    .rdata (rdata)
  );

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rst_q  <= 1'b1;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill_q <= '0;
      pkt_q  <= '0;
      state  <= IDLE;
    end else begin
      rst_q  <= 1'b0;
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_next;
      if (push && !pop)
        fill_q <= fill_q + 1'b1;
      else if (pop && !push)
        fill_q <= fill_q - 1'b1;
      if (push_last && !pop_last)
        pkt_q <= pkt_q + 1'b1;
      else if (pop_last && !push_last)
        pkt_q <= pkt_q - 1'b1;
      unique case (state)
        IDLE:    if (oversize_err) state <= RELEASE;
        RELEASE: if (pop_last) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/axis_pkt_fifo.md
Name: axis_pkt_fifo

Overview:
Parametrised AXI4-Stream FIFO carrying TDATA/TKEEP/TLAST, inserted between the stream master VIP and the stream slave VIP in the axis simulation block design.
- Two modes: cut-through, or store-and-forward (output held until a full packet, i.e. one ending in TLAST, is buffered).
- Exposes fill level and buffered-packet count for bench checking.
- Flags oversize packets that can never complete inside the FIFO.

Parameters:
DATA_W, 32, TDATA width in bits; multiple of 8, ≥8
DEPTH, 16, entries; power of 2, ≥2
STORE_FWD, 0, 0 = cut-through, 1 = store-and-forward

Ports:
aclk  in  1  clock; all logic on rising edge
aresetn  in  1  synchronous active-low reset
s_axis_tdata  in  DATA_W  input data
s_axis_tkeep  in  DATA_W/8  input byte enables
s_axis_tlast  in  1  input end of packet
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
m_axis_tdata  out  DATA_W  output data
m_axis_tkeep  out  DATA_W/8  output byte enables
m_axis_tlast  out  1  output end of packet
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
fill_level  out  $clog2(DEPTH)+1  words stored
pkt_count  out  $clog2(DEPTH)+1  complete packets stored
oversize_err  out  1  one-cycle pulse on forced release

Behaviour:
- Reset (aresetn low at a clock edge):
  - Pointers, fill_level, pkt_count and the release flag clear to 0.
  - s_axis_tready = 0 while aresetn is low; it becomes 1 on the first cycle after release.
  - m_axis_tvalid = 0, oversize_err = 0.
  - RAM contents are not cleared.
  - Reset mid-packet discards all stored words; no partial output continues after reset.
- Handshakes:
  - push = s_axis_tvalid & s_axis_tready.
  - pop = m_axis_tvalid & m_axis_tready.
  - s_axis_tready = !aresetn_q & (fill_level != DEPTH). It is a function of registers only, with no combinational path from m_axis_tready.
  - m_axis_tvalid and m_axis_tdata/tkeep/tlast are stable while tvalid=1 and tready=0.
- Pointers:
  - Read and write pointers are $clog2(DEPTH)+1 bits wide and wrap naturally.
  - full = MSBs differ and lower bits equal.
  - empty = pointers equal.
- Counters:
  - fill_level: +1 on push only, −1 on pop only, unchanged on both.
  - pkt_count: +1 on push with tlast, −1 on pop with tlast, unchanged when both occur in the same cycle.
- Latency:
  - A word pushed at edge N is visible on m_axis_* after edge N (cut-through; minimum 1 cycle) from an empty FIFO.
  - Output is backed by a registered read. With continuous tready, throughput is 1 word/cycle.
- Full and empty edge cases:
  - Push and pop in the same cycle at full: the pop happens; the push cannot, since tready=0.
  - Same cycle at empty: no pop.
- Cut-through (STORE_FWD=0): m_axis_tvalid = !empty.
- Store-and-forward (STORE_FWD=1):
  - m_axis_tvalid = !empty & (pkt_count != 0 | release).
  - Release flag:
    - Set when full & pkt_count == 0, with a 1-cycle oversize_err pulse in that same cycle.
    - Cleared on a pop with tlast.
    - While set, words drain as in cut-through mode.
  - TKEEP/TLAST pass through unmodified; no packets are dropped.
  - Sticky state (e.g. release) may be implemented as a small 2-state FSM: IDLE/RELEASE.
    - IDLE→RELEASE on the full-without-packet condition.
    - RELEASE→IDLE on pop & tlast.
- Scope: no TUSER/TID/TDEST. Those are for a later generation.

Decomposition:
- Package axis_pkt_fifo_pkg:
  - typedef struct packed {data, keep, last} axis_word_t, parametrised via localparam widths.
  - rel_state_t enum {IDLE, RELEASE}.
- Sub-module axis_fifo_ram: simple dual-port RAM with registered read, width = DATA_W + DATA_W/8 + 1, depth DEPTH.
- Top-level holds pointers, counters, FSM and output register.

Test Plan:
1. Cut-through, DEPTH=16, 5 single-word packets (tlast=1, data 0x00..0x04), m_tready=1 → each word appears 1 cycle after its push, in order; fill_level peaks at 1; pkt_count returns to 0.
2. Cut-through, m_tready=0, push 16 words → s_tready drops after the 16th push; fill_level=16; then m_tready oscillating low 2/high 3 drains 16 words in order, with data/keep stable while stalled.
3. Store-and-forward, 4-word packet with tlast on word 4, m_tready=1 → m_tvalid stays 0 until the cycle after the tlast push, then 4 back-to-back words; pkt_count goes 1→0.
4. Store-and-forward, DEPTH=8, 12-word packet → at fill_level=8 with pkt_count=0, oversize_err pulses once; all 12 words are delivered in order; release clears after the tlast pop.
5. Simultaneous push (tlast) and pop (tlast) with pkt_count=2 → pkt_count stays 2 and fill_level is unchanged.
6. aresetn low for 1 cycle mid-packet with fill_level=5 → next cycle fill_level=0, pkt_count=0, m_tvalid=0, s_tready=0 for that cycle and 1 after; a new packet then passes normally.
